// File: rtl/vga_timing_gen_if.sv
// Pixel-request and video-output bundle for vga_timing_gen.
// The test_mode input only exists when VGA_TESTPAT_EN is defined.
interface vga_timing_gen_if #(
    parameter int R_W = 3,
    parameter int G_W = 3,
    parameter int B_W = 2,
    parameter int X_W = 10,
    parameter int Y_W = 10
) ();
    logic [R_W-1:0] pix_r;
    logic [G_W-1:0] pix_g;
    logic [B_W-1:0] pix_b;
`ifdef VGA_TESTPAT_EN
    logic           test_mode;
`endif
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic           req;
    logic           pe;
    logic [R_W-1:0] red;
    logic [G_W-1:0] grn;
    logic [B_W-1:0] blu;
    logic           hsync;
    logic           vsync;
    logic           de;
    logic           frame_start;

    // Handshake: req is high while (x,y) lies in the active area; the pixel
    // source must hold pix_* valid for that coordinate until the next pe.
    // There is no back-pressure: the timing generator never waits.
`ifdef VGA_TESTPAT_EN
    modport master (input pix_r, pix_g, pix_b, test_mode,
                    output x, y, req, pe, red, grn, blu, hsync, vsync, de, frame_start);
    modport slave  (output pix_r, pix_g, pix_b, test_mode,
                    input x, y, req, pe, red, grn, blu, hsync, vsync, de, frame_start);
`else
    modport master (input pix_r, pix_g, pix_b,
                    output x, y, req, pe, red, grn, blu, hsync, vsync, de, frame_start);
    modport slave  (output pix_r, pix_g, pix_b,
                    input x, y, req, pe, red, grn, blu, hsync, vsync, de, frame_start);
`endif
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator with registered, blanked colour output.
// Define VGA_TESTPAT_EN to add the test_mode colour-bar generator.
module vga_timing_gen #(
    parameter int CLK_DIV  = 4,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int R_W      = 3,
    parameter int G_W      = 3,
    parameter int B_W      = 2,
    parameter int X_W      = 10,
    parameter int Y_W      = 10
) (
    input logic              clk,
    input logic              clr,
    vga_timing_gen_if.master vif
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [X_W-1:0]   H_LAST   = X_W'(H_TOTAL - 1);
    localparam logic [X_W-1:0]   H_ACT    = X_W'(H_ACTIVE);
    localparam logic [X_W-1:0]   HS_START = X_W'(H_ACTIVE + H_FP);
    localparam logic [X_W-1:0]   HS_END   = X_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_W-1:0]   V_LAST   = Y_W'(V_TOTAL - 1);
    localparam logic [Y_W-1:0]   V_ACT    = Y_W'(V_ACTIVE);
    localparam logic [Y_W-1:0]   VS_START = Y_W'(V_ACTIVE + V_FP);
    localparam logic [Y_W-1:0]   VS_END   = Y_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [X_W-1:0]   h_q, h_d;
    logic [Y_W-1:0]   v_q, v_d;
    logic [R_W-1:0]   red_q, red_d;
    logic [G_W-1:0]   grn_q, grn_d;
    logic [B_W-1:0]   blu_q, blu_d;
    logic             de_q, de_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic             fs_q, fs_d;
    logic             pe;
    logic             req;
    logic             pe_next;
`ifdef VGA_TESTPAT_EN
    logic [2:0]       bar;
`endif

    assign pe  = (div_q == DIV_LAST);
    assign req = (h_q < H_ACT) && (v_q < V_ACT);

    always_comb begin
        div_d = pe ? '0 : div_q + DIV_W'(1);
        h_d   = h_q;
        v_d   = v_q;
        red_d = red_q;
        grn_d = grn_q;
        blu_d = blu_q;
        de_d  = de_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
`ifdef VGA_TESTPAT_EN
        bar   = 3'((32'(h_q) * 8) / H_ACTIVE);
`endif
        if (pe) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + Y_W'(1);
            end else begin
                h_d = h_q + X_W'(1);
            end
            de_d  = req;
            red_d = '0;
            grn_d = '0;
            blu_d = '0;
            if (req) begin
`ifdef VGA_TESTPAT_EN
                // Bar order white..black maps to r=~bar[1], g=~bar[2], b=~bar[0].
                if (vif.test_mode) begin
                    red_d = {R_W{~bar[1]}};
                    grn_d = {G_W{~bar[2]}};
                    blu_d = {B_W{~bar[0]}};
                end else begin
                    red_d = vif.pix_r;
                    grn_d = vif.pix_g;
                    blu_d = vif.pix_b;
                end
`else
                red_d = vif.pix_r;
                grn_d = vif.pix_g;
                blu_d = vif.pix_b;
`endif
            end
            hs_d = (h_q >= HS_START && h_q < HS_END) ? HS_POL : ~HS_POL;
            vs_d = (v_q >= VS_START && v_q < VS_END) ? VS_POL : ~VS_POL;
        end
        // frame_start is registered one clk early so it coincides with the
        // pe of pixel (0,0); with CLK_DIV=1 the pixel at reset release is not flagged.
        pe_next = (div_d == DIV_LAST);
        fs_d    = pe_next && (h_d == '0) && (v_d == '0);
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            div_q <= '0;
            h_q   <= '0;
            v_q   <= '0;
            red_q <= '0;
            grn_q <= '0;
            blu_q <= '0;
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            fs_q  <= 1'b0;
        end else begin
            div_q <= div_d;
            h_q   <= h_d;
            v_q   <= v_d;
            red_q <= red_d;
            grn_q <= grn_d;
            blu_q <= blu_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
        end
    end

    assign vif.x           = h_q;
    assign vif.y           = v_q;
    assign vif.req         = req;
    assign vif.pe          = pe;
    assign vif.red         = red_q;
    assign vif.grn         = grn_q;
    assign vif.blu         = blu_q;
    assign vif.de          = de_q;
    assign vif.hsync       = hs_q;
    assign vif.vsync       = vs_q;
    assign vif.frame_start = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny 16x8
// instance with active-high syncs and CLK_DIV=1, both scored every clk.
module tb_vga_timing_gen;
    localparam int A_D = 4;
    localparam int A_HT = 800;
    localparam int A_VT = 525;
    localparam int B_D = 1;
    localparam int B_HT = 22;
    localparam int B_VT = 14;

    logic clk = 1'b0;
    logic clr = 1'b0;
    bit   tm_a = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    vga_timing_gen_if #(.R_W(3), .G_W(3), .B_W(2), .X_W(10), .Y_W(10)) va ();
    vga_timing_gen_if #(.R_W(3), .G_W(3), .B_W(2), .X_W(10), .Y_W(10)) vb ();

`ifdef VGA_TESTPAT_EN
    assign va.test_mode = tm_a;
    assign vb.test_mode = 1'b0;
`endif

    vga_timing_gen dut_a (.clk(clk), .clr(clr), .vif(va));

    vga_timing_gen #(
        .CLK_DIV(1), .H_ACTIVE(16), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(8), .V_FP(2), .V_SYNC(2), .V_BP(2),
        .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (.clk(clk), .clr(clr), .vif(vb));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    // Expected {de, r[3], g[3], b[2], hsync, vsync} for the pixel at (px,py).
    function automatic logic [10:0] exp_word(int px, int py, int ha, int hfp, int hsw,
                                             int vact, int vfp, int vsw, bit hpol, bit vpol,
                                             logic [7:0] rgb, bit tm);
        logic       act;
        logic [7:0] c;
        logic       hs;
        logic       vs;
        act = (px < ha) && (py < vact);
        c = 8'd0;
        if (act && !tm) c = rgb;
        if (act && tm) begin
            case (px * 8 / ha)
                0: c = 8'b111_111_11;
                1: c = 8'b111_111_00;
                2: c = 8'b000_111_11;
                3: c = 8'b000_111_00;
                4: c = 8'b111_000_11;
                5: c = 8'b111_000_00;
                6: c = 8'b000_000_11;
                default: c = 8'b000_000_00;
            endcase
        end
        hs = (px >= ha + hfp && px < ha + hfp + hsw) ? hpol : !hpol;
        vs = (py >= vact + vfp && py < vact + vfp + vsw) ? vpol : !vpol;
        return {act, c, hs, vs};
    endfunction

    // Reference model: clks since release decide everything by plain division.
    logic [10:0] exp_a_q[$];
    logic [10:0] exp_b_q[$];
    int ka = 0;
    int kb = 0;
    logic [10:0] cur_a;
    logic [10:0] cur_b;

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            ka <= 0;
            kb <= 0;
            exp_a_q.delete();
            exp_b_q.delete();
        end else begin
            ka <= ka + 1;
            kb <= kb + 1;
            if (ka % A_D == A_D - 1)
                exp_a_q.push_back(exp_word((ka / A_D) % A_HT, (ka / A_D / A_HT) % A_VT,
                                           640, 16, 96, 480, 10, 2, 1'b0, 1'b0,
                                           {va.pix_r, va.pix_g, va.pix_b}, tm_a));
            if (kb % B_D == B_D - 1)
                exp_b_q.push_back(exp_word((kb / B_D) % B_HT, (kb / B_D / B_HT) % B_VT,
                                           16, 2, 2, 8, 2, 2, 1'b1, 1'b1,
                                           {vb.pix_r, vb.pix_g, vb.pix_b}, 1'b0));
        end
    end

    task automatic score_a();
        int n;
        bit pe_e;
        n = ka / A_D;
        pe_e = (ka % A_D == A_D - 1);
        if (!clr) cur_a = 11'b0_00000000_1_1;
        else if (exp_a_q.size() > 0) cur_a = exp_a_q.pop_front();
        check("a_out", {va.de, va.red, va.grn, va.blu, va.hsync, va.vsync}, cur_a);
        check("a_x", va.x, n % A_HT);
        check("a_y", va.y, (n / A_HT) % A_VT);
        check("a_pe", va.pe, pe_e);
        check("a_req", va.req, ((n % A_HT) < 640) && (((n / A_HT) % A_VT) < 480));
        check("a_fs", va.frame_start, pe_e && (n % (A_HT * A_VT) == 0) && ka > 0);
    endtask

    task automatic score_b();
        int n;
        n = kb / B_D;
        if (!clr) cur_b = 11'b0_00000000_0_0;
        else if (exp_b_q.size() > 0) cur_b = exp_b_q.pop_front();
        check("b_out", {vb.de, vb.red, vb.grn, vb.blu, vb.hsync, vb.vsync}, cur_b);
        check("b_x", vb.x, n % B_HT);
        check("b_y", vb.y, (n / B_HT) % B_VT);
        check("b_pe", vb.pe, 1);
        check("b_req", vb.req, ((n % B_HT) < 16) && (((n / B_HT) % B_VT) < 8));
        check("b_fs", vb.frame_start, (n % (B_HT * B_VT) == 0) && kb > 0);
    endtask

    always @(negedge clk) begin
        score_a();
        score_b();
    end

    // Interval monitors on the outputs, restarted by every reset.
    int a_pe_gap, a_hs_low, a_hs_per, a_de_run;
    bit a_pe_seen, a_hs_fell, a_hs_prev;
    int b_hs_high, b_hs_per, b_vs_high, b_fs_gap, b_de_cnt;
    bit b_hs_rose, b_hs_prev, b_fs_seen;

    always @(negedge clk) begin
        if (!clr) begin
            a_pe_gap <= 0; a_pe_seen <= 1'b0; a_hs_low <= 0; a_hs_per <= 0;
            a_hs_fell <= 1'b0; a_hs_prev <= 1'b1; a_de_run <= 0;
        end else begin
            if (va.pe) begin
                if (a_pe_seen) check("a_pe_period", a_pe_gap + 1, 4);
                a_pe_gap <= 0;
                a_pe_seen <= 1'b1;
            end else a_pe_gap <= a_pe_gap + 1;
            if (!va.hsync) a_hs_low <= a_hs_low + 1;
            else begin
                if (a_hs_low != 0) check("a_hs_width", a_hs_low, 384);
                a_hs_low <= 0;
            end
            if (a_hs_prev && !va.hsync) begin
                if (a_hs_fell) check("a_hs_period", a_hs_per + 1, 3200);
                a_hs_per <= 0;
                a_hs_fell <= 1'b1;
            end else a_hs_per <= a_hs_per + 1;
            a_hs_prev <= va.hsync;
            if (va.de) a_de_run <= a_de_run + 1;
            else begin
                if (a_de_run != 0) check("a_de_width", a_de_run, 2560);
                a_de_run <= 0;
            end
            if (!tm_a) check("a_colour", {va.red, va.grn, va.blu}, va.de ? 8'b101_011_10 : 8'd0);
        end
    end

    always @(negedge clk) begin
        if (!clr) begin
            b_hs_high <= 0; b_hs_per <= 0; b_hs_rose <= 1'b0; b_hs_prev <= 1'b0;
            b_vs_high <= 0; b_fs_gap <= 0; b_fs_seen <= 1'b0; b_de_cnt <= 0;
        end else begin
            if (vb.hsync) b_hs_high <= b_hs_high + 1;
            else begin
                if (b_hs_high != 0) check("b_hs_width", b_hs_high, 2);
                b_hs_high <= 0;
            end
            if (!b_hs_prev && vb.hsync) begin
                if (b_hs_rose) check("b_hs_period", b_hs_per + 1, B_HT);
                b_hs_per <= 0;
                b_hs_rose <= 1'b1;
            end else b_hs_per <= b_hs_per + 1;
            b_hs_prev <= vb.hsync;
            if (vb.vsync) b_vs_high <= b_vs_high + 1;
            else begin
                if (b_vs_high != 0) check("b_vs_width", b_vs_high, 2 * B_HT);
                b_vs_high <= 0;
            end
            if (vb.frame_start) begin
                if (b_fs_seen) begin
                    check("b_fs_period", b_fs_gap + 1, B_HT * B_VT);
                    check("b_de_per_frame", b_de_cnt, 128);
                end
                b_fs_gap <= 0;
                b_fs_seen <= 1'b1;
                b_de_cnt <= 0;
            end else begin
                b_fs_gap <= b_fs_gap + 1;
                b_de_cnt <= b_de_cnt + int'(vb.de);
            end
        end
    end

    // Random colour for the small instance, changed well clear of the edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            vb.pix_r = 3'($urandom_range(0, 7));
            vb.pix_g = 3'($urandom_range(0, 7));
            vb.pix_b = 2'($urandom_range(0, 3));
        end
    end

    initial begin
        int lat;
        va.pix_r = 3'd5;
        va.pix_g = 3'd3;
        va.pix_b = 2'd2;
        vb.pix_r = 3'd0;
        vb.pix_g = 3'd0;
        vb.pix_b = 2'd0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1 clr = 1'b1;
        repeat (1500 + $urandom_range(0, 40)) @(posedge clk);

        // Asynchronous reset mid-frame, held for 3 clks.
        #2 clr = 1'b0;
        @(negedge clk);
        check("rst_a_hsync", va.hsync, 1);
        check("rst_a_vsync", va.vsync, 1);
        check("rst_a_rgb", {va.red, va.grn, va.blu}, 0);
        check("rst_a_de", va.de, 0);
        check("rst_a_xy", {va.x, va.y}, 0);
        check("rst_b_sync", {vb.hsync, vb.vsync}, 0);
        repeat (2) @(negedge clk);
        #1 clr = 1'b1;

        // pe of pixel (0,0) occupies the 4th clk after release, i.e. after 3 edges.
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (va.frame_start) begin
                lat = i;
                break;
            end
        end
        check("a_fs_latency", lat, A_D - 1);

        repeat (7000) @(posedge clk);
`ifdef VGA_TESTPAT_EN
        #2 tm_a = 1'b1;
`endif
        repeat (3500) @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing and pixel-output stage, successor to the fixed 640x480 controller inside VGA_TOP.
- Derives a pixel-rate enable from the system clock and runs horizontal and vertical counters.
- Publishes the current pixel coordinate to an upstream pixel source, then registers that source's colour, blanked, alongside hsync/vsync.
- Resolution, porches, sync polarity, clock divide and colour depth are all parameters.

Parameters:
- CLK_DIV, 4, system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync width (lines).
- V_BP, 33, vertical back porch (lines).
- HS_POL, 0, asserted level of hsync.
- VS_POL, 0, asserted level of vsync.
- R_W, 3, red width.
- G_W, 3, green width.
- B_W, 2, blue width.
- X_W, 10, x/h counter width (must hold H_TOTAL-1).
- Y_W, 10, y/v counter width (must hold V_TOTAL-1).

Ports:
- clk  in  1  system clock
- clr  in  1  asynchronous, active-low reset; 0 = reset
- pix_r  in  R_W  upstream red for coordinate (x,y)
- pix_g  in  G_W  upstream green
- pix_b  in  B_W  upstream blue
- x  out  X_W  current horizontal counter
- y  out  Y_W  current vertical counter
- req  out  1  (x,y) lies in the active area; pix_* must be valid
- pe  out  1  one-clk pixel-enable strobe
- red  out  R_W  registered, blanked red
- grn  out  G_W  registered, blanked green
- blu  out  B_W  registered, blanked blue
- hsync  out  1  registered horizontal sync
- vsync  out  1  registered vertical sync
- de  out  1  registered display-enable, aligned with red/grn/blu
- frame_start  out  1  one-clk pulse at the first pixel of each frame

Behaviour:
- Localparams: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider:
  - div counts 0..CLK_DIV-1, wraps to 0.
  - pe = 1 for the clk where div == CLK_DIV-1.
  - CLK_DIV = 1 gives pe permanently 1 after reset.
- Counters, advancing only on pe:
  - h_cnt counts 0..H_TOTAL-1, then wraps to 0.
  - v_cnt increments when h_cnt wraps; it wraps to 0 from V_TOTAL-1.
  - x = h_cnt, y = v_cnt (register outputs, no added logic).
- req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE). It is combinational from the counters and stable for the whole pixel period.
- Output registers update only on pe, from the pre-increment counter values:
  - de <= req.
  - red/grn/blu <= req ? pix_* : 0.
  - hsync <= HS_POL when h_cnt is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); otherwise ~HS_POL.
  - vsync <= VS_POL when v_cnt is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); otherwise ~VS_POL.
- Latency: colour, de, hsync and vsync all appear one pixel period after their coordinate is shown on x/y, so they are mutually aligned.
- frame_start = 1 for exactly one clk, on the clk where pe is high and h_cnt == 0 and v_cnt == 0.
- Reset (clr = 0, asynchronous, any time including mid-line):
  - div, h_cnt, v_cnt = 0.
  - red/grn/blu = 0, de = 0, frame_start = 0, pe = 0 (unless CLK_DIV = 1).
  - hsync = ~HS_POL, vsync = ~VS_POL.
- Release: the first pe comes CLK_DIV clks after clr rises, and that pe raises frame_start.
- Boundaries:
  - The last pixel of the last line wraps both counters to 0 on the same pe.
  - Blanking forces colour to 0 regardless of pix_*.
- No state machine beyond the counters; all outputs are glitch-free registers except req and pe.

Optional Feature:
- Macro: VGA_TESTPAT_EN.
- Defined:
  - Adds input port test_mode (1 bit).
  - When test_mode = 1, pix_* is ignored. The active area shows 8 equal vertical bars, bar index = h_cnt*8/H_ACTIVE, in order white, yellow, cyan, green, magenta, red, blue, black.
  - Each bar colour uses all-ones or zero per channel.
  - test_mode is sampled on pe.
- Undefined: no test_mode port; colour always comes from pix_*.

Test Plan:
- Reset: hold clr = 0 for 3 clks mid-frame.
  - During reset: hsync = vsync = 1, red = grn = blu = 0, de = 0, x = y = 0.
  - After release: first frame_start 4 clks after clr rises.
- Line timing (defaults):
  - pe period is 4 clks.
  - hsync low for exactly 96 pe periods (384 clks).
  - hsync period is 800 pe periods (3200 clks).
- Frame timing: vsync low for exactly 2 lines (6400 clks); frame_start period = 525*800*4 = 1,680,000 clks.
- Colour path: pix = (5,3,2) held constant.
  - Output = (5,3,2) only while de = 1; 0 in both porches.
  - de is high for exactly 640 pe per active line and 480 lines per frame.
- Parametric: HS_POL = 1, VS_POL = 1, CLK_DIV = 1, H/V set to a 16x8 active area with porches 2/2/2.
  - Sync pulses are active-high.
  - H_TOTAL = 22 pixels, wrap correct.
- VGA_TESTPAT_EN defined, test_mode = 1: pixel x = 0 shows (7,7,3); x = 639 shows (0,0,0); the first bar edge is at x = 80.
